// File: rtl/icache_refill_pkg.sv
// Shared widths, state encoding and address-split helpers for the
// instruction-cache refill responder.
package icache_refill_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int INST_WIDTH  = 32;
   localparam int ICACHE_SIZE = 16;
   localparam int INDEX_WIDTH = $clog2(ICACHE_SIZE);
   // Bit 0 is the halfword offset, so the tag sits above index + 1.
   localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      READ     = 2'd2,
      DONE     = 2'd3
   } refill_state_e;

   function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
      return a[ADDR_WIDTH-1 -: TAG_WIDTH];
   endfunction

   function automatic logic [INDEX_WIDTH-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[INDEX_WIDTH:1];
   endfunction

endpackage

// File: rtl/icache_refill.sv
// Memory-side responder for icache misses. Wins the byte-wide RAM bus,
// reads the four bytes at the miss PC and returns a one-cycle update
// bundle (little-endian word, tag/index, and the second-halfword fields).
//
// Ports:
//   clk, rst_in          clock, synchronous active-high reset
//   rdy_in               global ready; low freezes everything
//   clear_in             pipeline flush; aborts any refill
//   miss_en, miss_PC     miss request from the icache
//   update + mem2cache_* / is_c_inst / sec_inst_*   refill bundle
//   mem_req, mem_grant   arbiter handshake
//   mem_a, mem_wr        RAM byte address / write strobe (never writes)
//   mem_din              RAM read data, one cycle after its address
//
// state    | meaning
// IDLE     | waiting for a miss
// WAIT_GNT | bus requested, waiting for the arbiter
// READ     | issuing byte addresses and collecting bytes
// DONE     | bundle valid, update pulse
module icache_refill
   import icache_refill_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   clear_in,
   input  logic                   miss_en,
   input  logic [ADDR_WIDTH-1:0]  miss_PC,
   output logic                   update,
   output logic [INST_WIDTH-1:0]  mem2cache_inst,
   output logic [ADDR_WIDTH-1:0]  mem2cache_PC,
   output logic [TAG_WIDTH-1:0]   mem2cache_tag,
   output logic [INDEX_WIDTH-1:0] mem2cache_idx,
   output logic                   is_c_inst,
   output logic [ADDR_WIDTH-1:0]  sec_inst_addr,
   output logic [TAG_WIDTH-1:0]   sec_inst_tag,
   output logic [INDEX_WIDTH-1:0] sec_inst_index,
   output logic                   mem_req,
   input  logic                   mem_grant,
   output logic [ADDR_WIDTH-1:0]  mem_a,
   output logic                   mem_wr,
   input  logic [7:0]             mem_din
);

   refill_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  cap_q, cap_d;
   logic                  stall_q, stall_d;
   logic [INST_WIDTH-1:0] asm_q, asm_d;
   logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
   logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
   logic [ADDR_WIDTH-1:0] out_sec_q, out_sec_d;
   logic                  out_c_q, out_c_d;

   logic                  replay;
   logic [2:0]            off_sum;
   logic [1:0]            off;
   logic [INST_WIDTH-1:0] word;

   // cnt_q counts bytes already captured; cap_q says the byte on mem_din this
   // cycle belongs to an address we issued. The bus therefore runs one byte
   // ahead of the count, except on a replay after a stall, where the byte the
   // count is waiting for is re-requested because its data was dropped.
   always_comb begin
      replay  = stall_q & rdy_in & (state_q == READ);
      off_sum = {1'b0, cnt_q} + {2'b00, cap_q};
      if (replay)
         off = cnt_q;
      else if (off_sum[2])
         off = 2'd3;
      else
         off = off_sum[1:0];
      word = {mem_din, asm_q[INST_WIDTH-1:8]};
   end

   assign mem_req = (state_q == WAIT_GNT) || (state_q == READ);
   assign mem_a   = (state_q == READ) ? pc_q + {{(ADDR_WIDTH-2){1'b0}}, off} : '0;
   assign mem_wr  = 1'b0;
   assign update  = (state_q == DONE) & rdy_in & ~clear_in;

   assign mem2cache_inst = out_inst_q;
   assign mem2cache_PC   = out_pc_q;
   assign mem2cache_tag  = addr_tag(out_pc_q);
   assign mem2cache_idx  = addr_idx(out_pc_q);
   assign is_c_inst      = out_c_q;
   assign sec_inst_addr  = out_sec_q;
   assign sec_inst_tag   = addr_tag(out_sec_q);
   assign sec_inst_index = addr_idx(out_sec_q);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      cap_d      = cap_q;
      asm_d      = asm_q;
      out_inst_d = out_inst_q;
      out_pc_d   = out_pc_q;
      out_sec_d  = out_sec_q;
      out_c_d    = out_c_q;
      stall_d    = ~rdy_in;

      if (!rdy_in) begin
         // frozen
      end else if (clear_in) begin
         state_d = IDLE;
         cnt_d   = 2'd0;
         cap_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_en) begin
                  pc_d    = miss_PC;
                  cnt_d   = 2'd0;
                  cap_d   = 1'b0;
                  state_d = mem_grant ? READ : WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               if (mem_grant)
                  state_d = READ;
            end
            READ: begin
               cap_d = 1'b1;
               if (!replay && cap_q) begin
                  asm_d = word;
                  cnt_d = cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     state_d    = DONE;
                     out_inst_d = word;
                     out_pc_d   = pc_q;
                     out_sec_d  = pc_q + 32'd2;
                     out_c_d    = (word[1:0] != 2'b11);
                  end
               end
            end
            DONE: begin
               // miss_en ignored: the cache tag write lands at this edge
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         cnt_q      <= 2'd0;
         cap_q      <= 1'b0;
         stall_q    <= 1'b0;
         asm_q      <= '0;
         out_inst_q <= '0;
         out_pc_q   <= '0;
         out_sec_q  <= '0;
         out_c_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         cap_q      <= cap_d;
         stall_q    <= stall_d;
         asm_q      <= asm_d;
         out_inst_q <= out_inst_d;
         out_pc_q   <= out_pc_d;
         out_sec_q  <= out_sec_d;
         out_c_q    <= out_c_d;
      end
   end

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;
   import icache_refill_pkg::*;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in, clear_in, miss_en, mem_grant;
   logic [31:0] miss_PC;
   logic        update, is_c_inst, mem_req, mem_wr;
   logic [31:0] mem2cache_inst, mem2cache_PC, sec_inst_addr, mem_a;
   logic [26:0] mem2cache_tag, sec_inst_tag;
   logic [3:0]  mem2cache_idx, sec_inst_index;
   logic [7:0]  mem_din = 8'h00;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] ram [logic [31:0]];
   int         n_asserts = 0;
   int         n_fail    = 0;

   icache_refill dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .miss_en(miss_en), .miss_PC(miss_PC), .update(update),
      .mem2cache_inst(mem2cache_inst), .mem2cache_PC(mem2cache_PC),
      .mem2cache_tag(mem2cache_tag), .mem2cache_idx(mem2cache_idx),
      .is_c_inst(is_c_inst), .sec_inst_addr(sec_inst_addr),
      .sec_inst_tag(sec_inst_tag), .sec_inst_index(sec_inst_index),
      .mem_req(mem_req), .mem_grant(mem_grant), .mem_a(mem_a),
      .mem_wr(mem_wr), .mem_din(mem_din)
   );

   always #5 clk = ~clk;

   // byte RAM with one cycle read latency
   always @(posedge clk) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " update"}, update, 0);
      chk({tag, " mem_req"}, mem_req, 0);
      chk({tag, " mem_a"}, mem_a, 0);
      chk({tag, " mem_wr"}, mem_wr, 0);
      chk({tag, " inst"}, mem2cache_inst, 0);
      chk({tag, " pc"}, mem2cache_PC, 0);
      chk({tag, " tag"}, mem2cache_tag, 0);
      chk({tag, " idx"}, mem2cache_idx, 0);
      chk({tag, " is_c"}, is_c_inst, 0);
      chk({tag, " sec_addr"}, sec_inst_addr, 0);
      chk({tag, " sec_tag"}, sec_inst_tag, 0);
      chk({tag, " sec_idx"}, sec_inst_index, 0);
   endtask

   task automatic load(input logic [31:0] pc, input logic [31:0] w, input bit expect_update);
      exp_t e;
      for (int i = 0; i < 4; i++) ram[pc + 32'(i)] = w[8*i +: 8];
      if (expect_update) begin
         e.inst = w;
         e.pc   = pc;
         exp_q.push_back(e);
      end
   endtask

   // Present a miss for one cycle; returns at the negedge following acceptance.
   task automatic accept(input logic [31:0] pc, input logic g);
      miss_en   = 1'b1;
      miss_PC   = pc;
      mem_grant = g;
      @(negedge clk);
      miss_en   = 1'b0;
      miss_PC   = 32'hDEAD_0000;
   endtask

   // Wait for the update pulse, expected exp_n negedges from now, then check
   // the bundle against the scoreboard head and that the pulse is one cycle.
   task automatic wait_update(input string tag, input int exp_n);
      int          n;
      bit          seen;
      exp_t        e;
      logic [31:0] s;
      n    = 0;
      seen = 0;
      while (!seen && n < exp_n + 12) begin
         @(negedge clk);
         n++;
         if (update === 1'b1) seen = 1;
      end
      chk({tag, " latency"}, n, exp_n);
      if (seen) begin
         chk({tag, " sb depth"}, 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = e.pc + 32'd2;
            chk({tag, " inst"}, mem2cache_inst, e.inst);
            chk({tag, " pc"}, mem2cache_PC, e.pc);
            chk({tag, " tag"}, mem2cache_tag, {5'b0, e.pc[31:5]});
            chk({tag, " idx"}, mem2cache_idx, {28'b0, e.pc[4:1]});
            chk({tag, " is_c"}, is_c_inst, (e.inst[1:0] != 2'b11));
            chk({tag, " sec_addr"}, sec_inst_addr, s);
            chk({tag, " sec_tag"}, sec_inst_tag, {5'b0, s[31:5]});
            chk({tag, " sec_idx"}, sec_inst_index, {28'b0, s[4:1]});
         end
         chk({tag, " done mem_req"}, mem_req, 0);
         chk({tag, " done mem_a"}, mem_a, 0);
         @(negedge clk);
         chk({tag, " pulse width"}, update, 0);
         chk({tag, " after mem_req"}, mem_req, 0);
      end
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
      miss_en = 1'b0; miss_PC = 32'h0; mem_grant = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_in = 1'b0;
      @(negedge clk);

      // immediate grant, address sequence T0..T3
      load(32'h0000_1000, 32'h0010_0513, 1);
      accept(32'h0000_1000, 1'b1);
      chk("t1 req T0", mem_req, 1);
      chk("t1 mem_a T0", mem_a, 32'h0000_1000);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("t1 mem_a", mem_a, 32'h0000_1000 + 32'(i));
      end
      wait_update("t1", 2);
      mem_grant = 1'b0;
      chk("t1 tag const", mem2cache_tag, 32'h80);
      chk("t1 sec const", sec_inst_addr, 32'h1002);

      // compressed, index wrap; miss_en held high through DONE must be ignored
      load(32'h0000_101E, 32'h4585_4501, 1);
      miss_en = 1'b1; miss_PC = 32'h0000_101E; mem_grant = 1'b1;
      wait_update("t2", 6);
      miss_en = 1'b0; mem_grant = 1'b0;
      chk("t2 is_c const", is_c_inst, 1);
      chk("t2 idx const", mem2cache_idx, 32'hF);
      chk("t2 sec const", sec_inst_addr, 32'h1020);
      chk("t2 sec_tag const", sec_inst_tag, 32'h81);
      chk("t2 sec_idx const", sec_inst_index, 0);
      @(negedge clk);
      chk("t2 idle req", mem_req, 0);

      // grant delayed three cycles; grant cycle then T0..T4, update on sixth edge
      load(32'h0000_1100, 32'hFE01_0113, 1);
      accept(32'h0000_1100, 1'b0);
      chk("t3 wait req", mem_req, 1);
      chk("t3 wait mem_a", mem_a, 0);
      repeat (2) begin
         @(negedge clk);
         chk("t3 wait req", mem_req, 1);
         chk("t3 wait mem_a", mem_a, 0);
      end
      @(negedge clk);
      mem_grant = 1'b1;
      wait_update("t3", 6);
      mem_grant = 1'b0;

      // rdy_in low for four edges from T2, replay of PC+1
      load(32'h0000_3000, 32'h00A5_0593, 1);
      accept(32'h0000_3000, 1'b1);
      repeat (2) @(negedge clk);
      chk("t4 mem_a T2", mem_a, 32'h0000_3002);
      rdy_in = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t4 frozen mem_a", mem_a, 32'h0000_3002);
         chk("t4 frozen req", mem_req, 1);
         chk("t4 frozen update", update, 0);
      end
      @(negedge clk);
      chk("t4 frozen update", update, 0);
      rdy_in = 1'b1;
      #1;
      chk("t4 replay mem_a", mem_a, 32'h0000_3001);
      wait_update("t4", 4);
      mem_grant = 1'b0;

      // clear at T3 aborts the refill
      load(32'h0000_4000, 32'h1111_1111, 0);
      accept(32'h0000_4000, 1'b1);
      repeat (3) @(negedge clk);
      clear_in = 1'b1;
      @(negedge clk);
      clear_in = 1'b0;
      mem_grant = 1'b0;
      chk("t5 clr req", mem_req, 0);
      chk("t5 clr mem_a", mem_a, 0);
      repeat (7) begin
         @(negedge clk);
         chk("t5 no update", update, 0);
      end
      // miss together with clear is ignored
      clear_in = 1'b1; miss_en = 1'b1; miss_PC = 32'h0000_5000; mem_grant = 1'b1;
      @(negedge clk);
      clear_in = 1'b0; miss_en = 1'b0; mem_grant = 1'b0;
      chk("t5 clr+miss req", mem_req, 0);
      @(negedge clk);
      load(32'h0000_2000, 32'h0000_0297, 1);
      accept(32'h0000_2000, 1'b1);
      wait_update("t5", 5);
      mem_grant = 1'b0;

      // clear coinciding with DONE suppresses the pulse
      load(32'h0000_2100, 32'h1234_5678, 0);
      accept(32'h0000_2100, 1'b1);
      repeat (5) @(negedge clk);
      chk("t5b done update", update, 1);
      clear_in = 1'b1;
      #1;
      chk("t5b clr update", update, 0);
      @(negedge clk);
      clear_in = 1'b0;
      mem_grant = 1'b0;
      chk("t5b idle req", mem_req, 0);
      chk("t5b no update", update, 0);

      // reset mid-refill, then a wrapping miss
      load(32'h0000_6000, 32'h2222_2222, 0);
      accept(32'h0000_6000, 1'b1);
      repeat (2) @(negedge clk);
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      mem_grant = 1'b0;
      chk_zero("t6 reset");
      repeat (6) begin
         @(negedge clk);
         chk("t6 no update", update, 0);
      end
      load(32'hFFFF_FFFE, 32'h0010_0073, 1);
      accept(32'hFFFF_FFFE, 1'b1);
      chk("t6 mem_a T0", mem_a, 32'hFFFF_FFFE);
      @(negedge clk);
      chk("t6 mem_a T1", mem_a, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("t6 mem_a T2", mem_a, 32'h0000_0000);
      @(negedge clk);
      chk("t6 mem_a T3", mem_a, 32'h0000_0001);
      wait_update("t6", 2);
      mem_grant = 1'b0;
      chk("t6 sec const", sec_inst_addr, 32'h0);
      chk("t6 tag const", mem2cache_tag, 32'h07FF_FFFF);

      chk("sb empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
